// File: rtl/inj_scan_ctrl_if.sv
// inj_scan_ctrl_if: control, config and status bundle between the register layer and the scan sequencer
interface inj_scan_ctrl_if #(parameter int CNT_WIDTH = 16);
  logic                 START;
  logic                 STOP;
  logic [CNT_WIDTH-1:0] REPEAT;
  logic [CNT_WIDTH-1:0] PERIOD;
  logic [CNT_WIDTH-1:0] GATE_LEN;
  logic [CNT_WIDTH-1:0] INJ_DELAY;
  logic                 FIFO_NEAR_FULL;
  logic                 GATE;
  logic                 INJ_START;
  logic                 BUSY;
  logic                 STALLED;
  logic                 DONE;
  logic [CNT_WIDTH-1:0] INJ_CNT;
  modport master (
    output START, STOP, REPEAT, PERIOD, GATE_LEN, INJ_DELAY, FIFO_NEAR_FULL,
    input  GATE, INJ_START, BUSY, STALLED, DONE, INJ_CNT
  );
  modport slave (
    input  START, STOP, REPEAT, PERIOD, GATE_LEN, INJ_DELAY, FIFO_NEAR_FULL,
    output GATE, INJ_START, BUSY, STALLED, DONE, INJ_CNT
  );
endinterface

// File: rtl/inj_scan_ctrl.sv
// inj_scan_ctrl: gate-window / injection-start sequencer for charge-injection scans with FIFO back-pressure
module inj_scan_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic          CLK40,
  input  logic          nRST,
  inj_scan_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ARM, GATE_ON, GATE_OFF, FINISH} state_t;
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] t_q, t_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] rep_q, rep_d;
  logic [CNT_WIDTH-1:0] on_last_q, on_last_d;
  logic [CNT_WIDTH-1:0] per_last_q, per_last_d;
  logic [CNT_WIDTH-1:0] inj_pt_q, inj_pt_d;
  logic                 gate_q, gate_d;
  logic                 inj_q, inj_d;
  logic                 busy_q, busy_d;
  logic                 stall_q, stall_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] gl, gl_last, per_last, inj_pt;
  // Clamped timing from the live config; P-1 = max(PERIOD, GL+1)-1 is formed without needing GL+1
  always_comb begin
    gl       = (bus.GATE_LEN == '0) ? ONE : bus.GATE_LEN;
    gl_last  = gl - ONE;
    per_last = (bus.PERIOD > gl) ? bus.PERIOD - ONE : gl;
    inj_pt   = (bus.INJ_DELAY < gl_last) ? bus.INJ_DELAY : gl_last;
  end
  // Next state; the FIFO check for every gate after the first happens at the period boundary, so ARM only costs cycles while stalled
  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    cnt_d      = cnt_q;
    rep_d      = rep_q;
    on_last_d  = on_last_q;
    per_last_d = per_last_q;
    inj_pt_d   = inj_pt_q;
    stall_d    = 1'b0;
    case (state_q)
      IDLE: if (bus.START && !bus.STOP) begin
        state_d    = (bus.REPEAT == '0) ? FINISH : ARM;
        cnt_d      = '0;
        rep_d      = bus.REPEAT;
        on_last_d  = gl_last;
        per_last_d = per_last;
        inj_pt_d   = inj_pt;
      end
      ARM: if (bus.STOP) state_d = FINISH;
        else if (bus.FIFO_NEAR_FULL) stall_d = 1'b1;
        else begin
          state_d = GATE_ON;
          t_d     = '0;
        end
      GATE_ON: if (bus.STOP) state_d = FINISH;
        else begin
          t_d = t_q + ONE;
          if (t_q == on_last_q) begin
            state_d = GATE_OFF;
            cnt_d   = cnt_q + ONE;
          end
        end
      GATE_OFF: if (bus.STOP) state_d = FINISH;
        else if (t_q != per_last_q) t_d = t_q + ONE;
        else if (cnt_q == rep_q) state_d = FINISH;
        else if (bus.FIFO_NEAR_FULL) begin
          state_d = ARM;
          stall_d = 1'b1;
        end else begin
          state_d = GATE_ON;
          t_d     = '0;
        end
      default: state_d = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so that every output is a flop
  always_comb begin
    gate_d = state_d == GATE_ON;
    inj_d  = gate_d && (t_d == inj_pt_d);
    busy_d = state_d inside {ARM, GATE_ON, GATE_OFF};
    done_d = state_d == FINISH;
  end
  // State, counters, shadow config and registered outputs
  always_ff @(posedge CLK40 or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      t_q        <= '0;
      cnt_q      <= '0;
      rep_q      <= '0;
      on_last_q  <= '0;
      per_last_q <= '0;
      inj_pt_q   <= '0;
      gate_q     <= 1'b0;
      inj_q      <= 1'b0;
      busy_q     <= 1'b0;
      stall_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      cnt_q      <= cnt_d;
      rep_q      <= rep_d;
      on_last_q  <= on_last_d;
      per_last_q <= per_last_d;
      inj_pt_q   <= inj_pt_d;
      gate_q     <= gate_d;
      inj_q      <= inj_d;
      busy_q     <= busy_d;
      stall_q    <= stall_d;
      done_q     <= done_d;
    end
  end
  assign bus.GATE      = gate_q;
  assign bus.INJ_START = inj_q;
  assign bus.BUSY      = busy_q;
  assign bus.STALLED   = stall_q;
  assign bus.DONE      = done_q;
  assign bus.INJ_CNT   = cnt_q;
endmodule

// File: tb/tb_inj_scan_ctrl.sv
// tb_inj_scan_ctrl: self-checking bench for inj_scan_ctrl with a gate-schedule reference model
module tb_inj_scan_ctrl;
  localparam int W = 16;
  localparam int N = 400;
  typedef struct {
    int rep, per, gl, dly;
    int x_rise, x_gcyc, x_space, x_ioff, x_busy, x_cnt;
  } vec_t;
  logic CLK40 = 1'b0;
  logic nRST = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int rep, per, gl, dly;
  bit fnf[N], stp[N], sta[N];
  int eg[N], ei[N], eb[N], es[N], ed[N], ec[N];
  int end_c, cnt_prev;
  int m_rise, m_gcyc, m_r1, m_r2, m_inj, m_ioff, m_busy, m_done, m_stall, m_cnt;
  vec_t tbl[6];

  inj_scan_ctrl_if #(.CNT_WIDTH(W)) bus ();
  inj_scan_ctrl #(.CNT_WIDTH(W)) dut (.CLK40(CLK40), .nRST(nRST), .bus(bus.slave));

  always #5 CLK40 = ~CLK40;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_stim();
    for (int c = 0; c < N; c++) begin
      fnf[c] = 1'b0;
      stp[c] = 1'b0;
      sta[c] = 1'b0;
    end
  endtask

  // Expected output after each edge c (START sampled at edge 0), built from gate rise positions
  task automatic build_model();
    int gle, pe, ip, d, r, s;
    gle = (gl == 0) ? 1 : gl;
    pe  = (per > gle) ? per : gle + 1;
    ip  = (dly < gle - 1) ? dly : gle - 1;
    for (int c = 0; c < N; c++) begin
      eg[c] = 0; ei[c] = 0; eb[c] = 0; es[c] = 0; ed[c] = 0; ec[c] = 0;
    end
    if (stp[0]) begin
      for (int c = 0; c < N; c++) ec[c] = cnt_prev;
      end_c = 0;
      return;
    end
    d = 0;
    if (rep != 0) begin
      d = 1;
      for (int k = 0; k < rep; k++) begin
        while (fnf[d]) begin
          es[d] = 1;
          d++;
        end
        r = d;
        for (int j = 0; j < gle; j++) eg[r + j] = 1;
        ei[r + ip] = 1;
        for (int c = r + gle; c < N; c++) ec[c] = k + 1;
        d = r + pe;
      end
      for (int c = 0; c < d; c++) eb[c] = 1;
    end
    end_c = d;
    ed[d] = 1;
    s = -1;
    for (int c = N - 1; c >= 1; c--) if (stp[c]) s = c;
    if (s >= 1 && s <= end_c) begin
      for (int c = s; c < N; c++) begin
        eg[c] = 0; ei[c] = 0; eb[c] = 0; es[c] = 0; ed[c] = 0; ec[c] = ec[s - 1];
      end
      ed[s] = 1;
      end_c = s;
    end
  endtask

  // Drives one scan, compares every cycle against the model and records waveform statistics
  task automatic run_scan(input int id);
    logic [20:0] act, exp;
    logic gprev;
    build_model();
    m_rise = 0; m_gcyc = 0; m_r1 = -1; m_r2 = -1; m_inj = 0; m_ioff = -1;
    m_busy = 0; m_done = 0; m_stall = 0; m_cnt = 0;
    gprev = 1'b0;
    for (int c = 0; c <= end_c + 2; c++) begin
      @(negedge CLK40);
      bus.START = (c == 0) || sta[c];
      bus.STOP = stp[c];
      bus.FIFO_NEAR_FULL = fnf[c];
      if (c == 0) begin
        bus.REPEAT = W'(rep); bus.PERIOD = W'(per); bus.GATE_LEN = W'(gl); bus.INJ_DELAY = W'(dly);
      end else begin
        bus.REPEAT = W'($urandom_range(0, 5)); bus.PERIOD = W'($urandom_range(0, 12));
        bus.GATE_LEN = W'($urandom_range(0, 6)); bus.INJ_DELAY = W'($urandom_range(0, 8));
      end
      @(posedge CLK40);
      #1;
      act = {bus.GATE, bus.INJ_START, bus.BUSY, bus.STALLED, bus.DONE, bus.INJ_CNT};
      exp = {1'(eg[c]), 1'(ei[c]), 1'(eb[c]), 1'(es[c]), 1'(ed[c]), W'(ec[c])};
      check($sformatf("scan%0d_cyc%0d {gate,inj,busy,stall,done,cnt}", id, c), 64'(act), 64'(exp));
      if (bus.GATE && !gprev) begin
        m_rise++;
        if (m_r1 < 0) m_r1 = c;
        else if (m_r2 < 0) m_r2 = c;
      end
      gprev = bus.GATE;
      if (bus.INJ_START && m_ioff < 0 && m_r1 >= 0) m_ioff = c - m_r1;
      m_gcyc  += int'(bus.GATE);
      m_inj   += int'(bus.INJ_START);
      m_busy  += int'(bus.BUSY);
      m_done  += int'(bus.DONE);
      m_stall += int'(bus.STALLED);
      m_cnt    = int'(bus.INJ_CNT);
    end
    @(negedge CLK40);
    bus.START = 1'b0;
    bus.STOP = 1'b0;
    bus.FIFO_NEAR_FULL = 1'b0;
    cnt_prev = ec[end_c];
    clear_stim();
  endtask

  initial begin
    logic ok;
    tbl[0] = '{3, 10, 4, 1, 3, 12, 10, 1, 31, 3};
    tbl[1] = '{2, 1, 0, 7, 2, 2, 2, 0, 5, 2};
    tbl[2] = '{1, 5, 3, 0, 1, 3, 0, 0, 6, 1};
    tbl[3] = '{2, 3, 5, 9, 2, 10, 6, 4, 13, 2};
    tbl[4] = '{3, 0, 2, 1, 3, 6, 3, 1, 10, 3};
    tbl[5] = '{0, 10, 4, 1, 0, 0, 0, -1, 0, 0};
    bus.START = 1'b0; bus.STOP = 1'b0; bus.FIFO_NEAR_FULL = 1'b0;
    bus.REPEAT = '0; bus.PERIOD = '0; bus.GATE_LEN = '0; bus.INJ_DELAY = '0;
    cnt_prev = 0;
    clear_stim();
    #1 nRST = 1'b0;
    #1;
    check("reset_state", 64'({bus.GATE, bus.INJ_START, bus.BUSY, bus.STALLED, bus.DONE, bus.INJ_CNT}), 64'd0);
    repeat (3) @(posedge CLK40);
    @(negedge CLK40) nRST = 1'b1;
    @(negedge CLK40);

    for (int i = 0; i < 6; i++) begin
      rep = tbl[i].rep; per = tbl[i].per; gl = tbl[i].gl; dly = tbl[i].dly;
      run_scan(i);
      check($sformatf("tbl%0d_rises", i), 64'(m_rise), 64'(tbl[i].x_rise));
      check($sformatf("tbl%0d_gate_cycles", i), 64'(m_gcyc), 64'(tbl[i].x_gcyc));
      check($sformatf("tbl%0d_rise_spacing", i), 64'((m_r2 < 0) ? 0 : m_r2 - m_r1), 64'(tbl[i].x_space));
      check($sformatf("tbl%0d_inj_offset", i), 64'(m_ioff), 64'(tbl[i].x_ioff));
      check($sformatf("tbl%0d_inj_pulses", i), 64'(m_inj), 64'(tbl[i].x_rise));
      check($sformatf("tbl%0d_busy_cycles", i), 64'(m_busy), 64'(tbl[i].x_busy));
      check($sformatf("tbl%0d_done_pulses", i), 64'(m_done), 64'd1);
      check($sformatf("tbl%0d_final_cnt", i), 64'(m_cnt), 64'(tbl[i].x_cnt));
    end

    // back-pressure across the second gate's start boundary
    rep = 2; per = 10; gl = 4; dly = 1;
    for (int c = 11; c <= 15; c++) fnf[c] = 1'b1;
    run_scan(20);
    check("bp_stalled_cycles", 64'(m_stall), 64'd5);
    check("bp_rise_spacing", 64'(m_r2 - m_r1), 64'd15);
    check("bp_final_cnt", 64'(m_cnt), 64'd2);

    // abort in the second cycle of gate 2
    rep = 4; per = 10; gl = 4; dly = 1;
    stp[13] = 1'b1;
    run_scan(21);
    check("abort_inj_pulses", 64'(m_inj), 64'd2);
    check("abort_done_pulses", 64'(m_done), 64'd1);
    check("abort_final_cnt", 64'(m_cnt), 64'd1);

    // START together with STOP
    rep = 3; per = 10; gl = 4; dly = 1;
    stp[0] = 1'b1;
    run_scan(22);
    check("startstop_busy", 64'(m_busy), 64'd0);
    check("startstop_done", 64'(m_done), 64'd0);

    // START while busy
    rep = 3; per = 10; gl = 4; dly = 1;
    sta[5] = 1'b1; sta[12] = 1'b1; sta[25] = 1'b1;
    run_scan(23);
    check("rebusy_rises", 64'(m_rise), 64'd3);
    check("rebusy_spacing", 64'(m_r2 - m_r1), 64'd10);

    // asynchronous reset in the middle of the second gate
    @(negedge CLK40);
    bus.REPEAT = W'(3); bus.PERIOD = W'(10); bus.GATE_LEN = W'(4); bus.INJ_DELAY = W'(1);
    bus.START = 1'b1;
    @(negedge CLK40);
    bus.START = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge CLK40);
      #1;
      ok = bus.GATE && (bus.INJ_CNT == W'(1));
    end
    check("rst_mid_gate_reached", 64'(ok), 64'd1);
    #2 nRST = 1'b0;
    #1;
    check("rst_async_outputs", 64'({bus.GATE, bus.INJ_START, bus.BUSY, bus.STALLED, bus.DONE, bus.INJ_CNT}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK40);
      #1;
      check($sformatf("rst_hold%0d_outputs", i), 64'({bus.GATE, bus.INJ_START, bus.BUSY, bus.STALLED, bus.DONE, bus.INJ_CNT}), 64'd0);
    end
    @(negedge CLK40) nRST = 1'b1;
    @(negedge CLK40);
    cnt_prev = 0;
    rep = 2; per = 6; gl = 3; dly = 2;
    run_scan(24);
    check("rst_rerun_cnt", 64'(m_cnt), 64'd2);

    // randomized scans against the model
    for (int k = 0; k < 40; k++) begin
      rep = $urandom_range(0, 4); per = $urandom_range(0, 12);
      gl = $urandom_range(0, 6); dly = $urandom_range(0, 8);
      for (int c = 1; c < 150; c++) fnf[c] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) stp[$urandom_range(1, 60)] = 1'b1;
      build_model();
      for (int c = 1; c <= end_c; c++) sta[c] = ($urandom_range(0, 9) == 0);
      run_scan(100 + k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
